// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared BCD and game-state definitions for the dino score keeper
package dino_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } game_state_t;

endpackage

// File: rtl/dino_score_bcd_digit.sv
// rtl/dino_score_bcd_digit.sv - one decade cell of the ripple BCD score counter
module bcd_digit
  import dino_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc_in,
  input  logic clr,
  output bcd_t digit,
  output logic carry_out
);

  assign carry_out = inc_in && (digit == BCD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc_in) begin
      digit <= (digit == BCD_MAX) ? '0 : digit + bcd_t'(1);
    end
  end

endmodule

// File: rtl/dino_score_bcd.sv
// rtl/dino_score_bcd.sv - BCD score keeper with game FSM, high score and speed level
module dino_score_bcd
  import dino_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int LEVEL_DIGIT = 2,
  parameter int MAX_LEVEL   = 7
) (
  input  logic                            clock_out,
  input  logic                            Rst,
  input  logic                            start,
  input  logic                            tick,
  input  logic                            stop,
  output logic [BCD_W*NUM_DIGITS-1:0]     score,
  output logic [BCD_W*NUM_DIGITS-1:0]     hiscore,
  output logic                            new_record,
  output logic [$clog2(MAX_LEVEL+1)-1:0]  level,
  output logic                            saturated,
  output logic [1:0]                      game_state
);

  localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);

  game_state_t           state;
  logic                  clr;
  logic                  inc;
  logic [NUM_DIGITS:0]   carry;
  logic                  will_saturate;
  logic                  nines_above;

  assign game_state = state;
  assign clr = start && (state == ST_IDLE || state == ST_DEAD);
  // Increment is gated by the registered saturation flag so the score never wraps.
  assign inc = (state == ST_RUN) && tick && !stop && !saturated;
  assign carry[0] = inc;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_t d;
    bcd_digit u_digit (
      .clk       (clock_out),
      .rst       (Rst),
      .inc_in    (carry[i]),
      .clr       (clr),
      .digit     (d),
      .carry_out (carry[i+1])
    );
    assign score[BCD_W*i +: BCD_W] = d;
  end

  // This increment lands on all-9s when digit 0 is 8 and every higher digit is 9.
  always_comb begin
    nines_above = 1'b1;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (score[BCD_W*k +: BCD_W] != BCD_MAX) nines_above = 1'b0;
    end
    will_saturate = inc && nines_above && (score[BCD_W-1:0] == BCD_MAX - bcd_t'(1));
  end

  always_ff @(posedge clock_out or posedge Rst) begin
    if (Rst) begin
      state      <= ST_IDLE;
      hiscore    <= '0;
      new_record <= 1'b0;
      level      <= '0;
      saturated  <= 1'b0;
    end else begin
      new_record <= 1'b0;
      case (state)
        ST_IDLE, ST_DEAD: begin
          if (start) begin
            state     <= ST_RUN;
            level     <= '0;
            saturated <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_DEAD;
            if (score > hiscore) begin
              hiscore    <= score;
              new_record <= 1'b1;
            end
          end else begin
            if (carry[LEVEL_DIGIT] && level != LEVEL_W'(MAX_LEVEL)) begin
              level <= level + LEVEL_W'(1);
            end
            if (will_saturate || carry[NUM_DIGITS]) saturated <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dino_score_bcd.sv
// tb/tb_dino_score_bcd.sv - directed self-checking bench for dino_score_bcd
module tb_dino_score_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, tick = 1'b0, stop = 1'b0;
  logic        start_s = 1'b0, tick_s = 1'b0, stop_s = 1'b0;
  logic [15:0] score, hiscore;
  logic [7:0]  score_s, hiscore_s;
  logic        new_record, saturated, new_record_s, saturated_s;
  logic [2:0]  level, level_s;
  logic [1:0]  game_state, game_state_s;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dino_score_bcd #(.NUM_DIGITS(4), .LEVEL_DIGIT(2), .MAX_LEVEL(7)) dut (
    .clock_out(clk), .Rst(rst), .start(start), .tick(tick), .stop(stop),
    .score(score), .hiscore(hiscore), .new_record(new_record), .level(level),
    .saturated(saturated), .game_state(game_state)
  );

  dino_score_bcd #(.NUM_DIGITS(2), .LEVEL_DIGIT(1), .MAX_LEVEL(7)) dut_s (
    .clock_out(clk), .Rst(rst), .start(start_s), .tick(tick_s), .stop(stop_s),
    .score(score_s), .hiscore(hiscore_s), .new_record(new_record_s), .level(level_s),
    .saturated(saturated_s), .game_state(game_state_s)
  );

  task automatic ticks(input int n);
    @(negedge clk) tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks_s(input int n);
    @(negedge clk) tick_s = 1'b1;
    repeat (n) @(negedge clk);
    tick_s = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (score !== 16'h0) begin n_fail++; $display("FAIL reset_score got %h want 0000", score); end
    n_cmp++; if (hiscore !== 16'h0) begin n_fail++; $display("FAIL reset_hiscore got %h want 0000", hiscore); end
    n_cmp++; if ({new_record, saturated, level, game_state} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags got nr=%b sat=%b lvl=%0d st=%0d want all 0", new_record, saturated, level, game_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_count();
    pulse_start();
    n_cmp++; if (game_state !== 2'd1 || score !== 16'h0) begin
      n_fail++; $display("FAIL start_run got st=%0d score=%h want 1/0000", game_state, score);
    end
    ticks(23);
    n_cmp++; if (score !== 16'h0023 || game_state !== 2'd1 || level !== 3'd0) begin
      n_fail++; $display("FAIL basic_count got score=%h st=%0d lvl=%0d want 0023/1/0", score, game_state, level);
    end
    @(negedge clk) begin start = 1'b1; tick = 1'b1; end
    @(negedge clk) begin start = 1'b0; tick = 1'b0; end
    n_cmp++; if (score !== 16'h0024 || game_state !== 2'd1) begin
      n_fail++; $display("FAIL start_ignored_in_run got score=%h st=%0d want 0024/1", score, game_state);
    end
  endtask

  task automatic test_carry_level();
    ticks(75);
    n_cmp++; if (score !== 16'h0099 || level !== 3'd0) begin
      n_fail++; $display("FAIL pre_carry got score=%h lvl=%0d want 0099/0", score, level);
    end
    ticks(1);
    n_cmp++; if (score !== 16'h0100 || level !== 3'd1) begin
      n_fail++; $display("FAIL carry_level1 got score=%h lvl=%0d want 0100/1", score, level);
    end
    ticks(100);
    n_cmp++; if (score !== 16'h0200 || level !== 3'd2) begin
      n_fail++; $display("FAIL carry_level2 got score=%h lvl=%0d want 0200/2", score, level);
    end
  endtask

  task automatic test_death_tick();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    pulse_start();
    ticks(41);
    @(negedge clk) begin stop = 1'b1; tick = 1'b1; end
    @(negedge clk) begin stop = 1'b0; tick = 1'b0; end
    n_cmp++; if (score !== 16'h0041 || game_state !== 2'd2) begin
      n_fail++; $display("FAIL death_freeze got score=%h st=%0d want 0041/2", score, game_state);
    end
    n_cmp++; if (hiscore !== 16'h0041 || new_record !== 1'b1) begin
      n_fail++; $display("FAIL death_record got hi=%h nr=%b want 0041/1", hiscore, new_record);
    end
    @(negedge clk);
    n_cmp++; if (new_record !== 1'b0 || score !== 16'h0041) begin
      n_fail++; $display("FAIL record_pulse_end got nr=%b score=%h want 0/0041", new_record, score);
    end
  endtask

  task automatic test_no_record();
    pulse_start();
    n_cmp++; if (score !== 16'h0 || game_state !== 2'd1) begin
      n_fail++; $display("FAIL restart_clear got score=%h st=%0d want 0000/1", score, game_state);
    end
    ticks(30);
    pulse_stop();
    n_cmp++; if (hiscore !== 16'h0041 || new_record !== 1'b0 || score !== 16'h0030) begin
      n_fail++; $display("FAIL lower_score got hi=%h nr=%b score=%h want 0041/0/0030", hiscore, new_record, score);
    end
    pulse_start();
    ticks(41);
    pulse_stop();
    n_cmp++; if (hiscore !== 16'h0041 || new_record !== 1'b0 || game_state !== 2'd2) begin
      n_fail++; $display("FAIL tie_score got hi=%h nr=%b st=%0d want 0041/0/2", hiscore, new_record, game_state);
    end
    pulse_start();
    ticks(42);
    pulse_stop();
    n_cmp++; if (hiscore !== 16'h0042 || new_record !== 1'b1) begin
      n_fail++; $display("FAIL higher_score got hi=%h nr=%b want 0042/1", hiscore, new_record);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    ticks_s(98);
    n_cmp++; if (score_s !== 8'h98 || saturated_s !== 1'b0 || level_s !== 3'd7) begin
      n_fail++; $display("FAIL sat_before got score=%h sat=%b lvl=%0d want 98/0/7", score_s, saturated_s, level_s);
    end
    ticks_s(1);
    n_cmp++; if (score_s !== 8'h99 || saturated_s !== 1'b1) begin
      n_fail++; $display("FAIL sat_reach got score=%h sat=%b want 99/1", score_s, saturated_s);
    end
    ticks_s(21);
    n_cmp++; if (score_s !== 8'h99 || saturated_s !== 1'b1 || level_s !== 3'd7) begin
      n_fail++; $display("FAIL sat_hold got score=%h sat=%b lvl=%0d want 99/1/7", score_s, saturated_s, level_s);
    end
    @(negedge clk) stop_s = 1'b1;
    @(negedge clk) begin stop_s = 1'b0; start_s = 1'b1; end
    @(negedge clk) start_s = 1'b0;
    n_cmp++; if (score_s !== 8'h00 || saturated_s !== 1'b0 || level_s !== 3'd0 || hiscore_s !== 8'h99) begin
      n_fail++; $display("FAIL sat_restart got score=%h sat=%b lvl=%0d hi=%h want 00/0/0/99", score_s, saturated_s, level_s, hiscore_s);
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    ticks(5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (score !== 16'h0 || hiscore !== 16'h0 || level !== 3'd0 || new_record !== 1'b0 ||
                 saturated !== 1'b0 || game_state !== 2'd0) begin
      n_fail++; $display("FAIL async_reset got score=%h hi=%h lvl=%0d nr=%b sat=%b st=%0d want all 0",
                         score, hiscore, level, new_record, saturated, game_state);
    end
    @(negedge clk) rst = 1'b0;
    ticks(3);
    n_cmp++; if (score !== 16'h0 || game_state !== 2'd0) begin
      n_fail++; $display("FAIL idle_tick got score=%h st=%0d want 0000/0", score, game_state);
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_carry_level();
    test_death_tick();
    test_no_record();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dino_score_bcd.md
# dino_score_bcd

- Parametrised BCD score keeper for the dinosaur runner game: N-digit decimal score, a game-state machine (idle / running / dead), a persistent high score, and a speed-level counter.
- The score advances on a game-tick strobe and freezes on collision.
- Sits between the collision/obstacle logic (which supplies `stop`) and the 7-segment display driver (which consumes `score` and `hiscore`).
- It supersedes the fixed two-digit units/tens death counter.

## Interface

Parameters:
- `NUM_DIGITS`, 4: number of BCD digits in the score and high score (≥1).
- `LEVEL_DIGIT`, 2: the level advances on each carry out of digit `LEVEL_DIGIT-1`, i.e. every 10^`LEVEL_DIGIT` points (1 ≤ `LEVEL_DIGIT` < `NUM_DIGITS`).
- `MAX_LEVEL`, 7: level saturates at this value.

Ports:
- `clock_out`, in, 1: system clock. All updates occur on its rising edge.
- `Rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin or restart a game. Level-sampled each edge.
- `tick`, in, 1: one-cycle score strobe from the game timer.
- `stop`, in, 1: collision/death indication.
- `score`, out, 4·NUM_DIGITS: current score, packed BCD; digit 0 in bits [3:0].
- `hiscore`, out, 4·NUM_DIGITS: best score since reset, packed BCD.
- `new_record`, out, 1: one-cycle pulse when `hiscore` is updated.
- `level`, out, clog2(MAX_LEVEL+1): speed level for the obstacle generator.
- `saturated`, out, 1: score is at its maximum value (all digits 9).
- `game_state`, out, 2: 0 = IDLE, 1 = RUN, 2 = DEAD.

## Operation

State machine:
- **IDLE**
  - `start`=1 → RUN.
  - Score and level are cleared on the same edge.
- **RUN**
  - `stop`=1 → DEAD.
  - Otherwise, `tick`=1 increments the score by 1.
  - `start` is ignored.
- **DEAD**
  - `start`=1 → RUN, clearing score, level and `saturated` on the same edge.
  - Otherwise all values hold.
- Encoding 3 is unreachable; if entered, the next edge goes to IDLE.

Score increment (ripple BCD):
- Digit k increments if all lower digits are 9. A digit at 9 wraps to 0 and carries.
- No digit ever holds a value greater than 9.

Saturation:
- At all-9s, `saturated`=1 and further ticks have no effect; the score never wraps to 0.

Level:
- +1 on each increment that carries out of digit `LEVEL_DIGIT-1` into digit `LEVEL_DIGIT`.
- Saturates at `MAX_LEVEL`.

Priority and simultaneous events:
- `stop` beats `tick` in the same cycle: no increment, transition to DEAD.
- In DEAD, `start` and `stop` together: `start` wins.

High score:
- Updated on the RUN→DEAD edge only: if `score` > `hiscore` (strict), then `hiscore` ← `score`.
- The comparison is a plain unsigned compare of the packed BCD vectors, which is valid because BCD ordering is monotone.
- A tie leaves `hiscore` unchanged and produces no pulse.

`new_record`:
- Set on the same edge as the high-score update; cleared on the following edge.

## Timing

Reset (`Rst`=1):
- Immediately and asynchronously: `score`=0, `hiscore`=0, `level`=0, `new_record`=0, `saturated`=0, `game_state`=IDLE.
- This holds mid-game as well; the high score is not retained across reset.

Latency:
- `tick` sampled at edge n → new `score`, `level` and `saturated` visible after edge n.
- `stop` at edge n → `game_state`=DEAD, `hiscore` and `new_record` valid after edge n.
- `new_record` is low again after edge n+1.

Restart:
- `start` in DEAD at edge n → `score`=0 after edge n.
- A `tick` at edge n is not counted; the first count is at edge n+1.

`saturated`:
- Registered; asserts after the edge on which the score reaches all-9s.

## Structure

Shared package `dino_pkg`:
- Game-state encoding constants (IDLE/RUN/DEAD).
- BCD digit width (4) and the BCD maximum digit value (9).
- Typedef for a BCD digit.

Sub-module `bcd_digit`:
- One decade cell with inputs `inc_in` and `clr`, outputs `digit` and `carry_out`.
- Instantiated `NUM_DIGITS` times in a generate loop; carry is chained from digit 0 upward.

Top level contains:
- The FSM.
- The high-score register and comparator.
- The level counter and saturation logic.

## Test plan

All scenarios use `NUM_DIGITS`=4, `LEVEL_DIGIT`=2 unless noted.

1. **Basic count:** reset, `start`, 23 `tick` pulses → `score`=16'h0023, `game_state`=RUN, `level`=0.
2. **Carry and level:** tick to 0x0099, one more tick → `score`=0x0100, `level`=1. Another 100 ticks → 0x0200, `level`=2.
3. **Death with simultaneous tick:** at 0x0041, `stop`=1 and `tick`=1 in the same cycle → `score` stays 0x0041, DEAD, `hiscore`=0x0041, `new_record` high exactly one cycle.
4. **No record on lower score or tie:** `start` → `score`=0. Reach 0x0030 and `stop` → `hiscore` stays 0x0041, no pulse. Restart, reach 0x0041 and `stop` → still no pulse.
5. **Saturation (`NUM_DIGITS`=2, `LEVEL_DIGIT`=1, `MAX_LEVEL`=7):** 120 ticks → `score`=0x99, `saturated`=1, `level`=7 (saturated). Further ticks → no change.
6. **Asynchronous reset mid-game:** assert `Rst` mid-RUN between clock edges with `hiscore` nonzero → all outputs 0 and IDLE before the next edge. After release, `tick` without `start` → `score` stays 0.
